// File: rtl/lab_pkg.sv
// Shared types and helpers for the FX chain: gate FSM states, unity gain and
// signed saturation to an arbitrary sample width.
package lab_pkg;

    typedef enum logic [2:0] {
        ST_CLOSED,
        ST_ATTACK,
        ST_OPEN,
        ST_HOLD,
        ST_RELEASE
    } gate_state_t;

    localparam logic [7:0] GATE_UNITY = 8'd128;

    // Clamp a signed value into the range of a signed word of the given width.
    function automatic logic signed [31:0] sat16(input logic signed [31:0] value,
                                                 input int unsigned   width = 16);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/fx_level_detect.sv
// Stereo peak level detector with open/close threshold compares.
// FX_NOISE_GATE_HYST_EN: close compare uses half the open threshold.
module fx_level_detect #(
    parameter int DATA_W  = 16,
    parameter int PARAM_W = 8
) (
    input  logic [1:0][DATA_W-1:0] audio_in,
    input  logic [PARAM_W-1:0]     gate_thresh,
    output logic                   above_open,
    output logic                   above_close
);

    localparam int              PAD_W    = DATA_W - PARAM_W;
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic [1:0][DATA_W-1:0] mag;
    logic [DATA_W-1:0]      level;
    logic [DATA_W-1:0]      thr_open;
    logic [DATA_W-1:0]      thr_close;

    // The most negative sample has no positive twin, so it clamps to full scale.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            if (audio_in[ch] == MOST_NEG)
                mag[ch] = ~MOST_NEG;
            else if (audio_in[ch][DATA_W-1])
                mag[ch] = -audio_in[ch];
            else
                mag[ch] = audio_in[ch];
        end
    end

    assign level    = (mag[0] > mag[1]) ? mag[0] : mag[1];
    assign thr_open = DATA_W'(gate_thresh) << PAD_W;

`ifdef FX_NOISE_GATE_HYST_EN
    assign thr_close = DATA_W'(gate_thresh >> 1) << PAD_W;
`else
    assign thr_close = thr_open;
`endif

    assign above_open  = (level >= thr_open);
    assign above_close = (level >= thr_close);

endmodule

// File: rtl/fx_noise_gate.sv
// Stereo noise gate: five-state gain envelope applied to both channels.
// Optional hysteresis on the close threshold via FX_NOISE_GATE_HYST_EN.
module fx_noise_gate
    import lab_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int PARAM_W      = 8,
    parameter int HOLD_SAMPLES = 480,
    parameter int ATTACK_STEP  = 16,
    parameter int RELEASE_STEP = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sample_en,
    input  logic [1:0][DATA_W-1:0] audio_in,
    input  logic [PARAM_W-1:0]     gate_thresh,
    output logic [1:0][DATA_W-1:0] audio_out,
    output logic                   gate_open
);

    localparam int CNT_W = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;

    gate_state_t            state_q, state_d;
    logic [7:0]             g_q, g_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0][DATA_W-1:0] audio_out_q, audio_out_d;
    logic                   gate_open_q;

    logic                   above_open;
    logic                   above_close;
    logic [8:0]             g_sum;
    logic [7:0]             g_up;
    logic [7:0]             g_dn;
    logic signed [DATA_W+8:0] prod [2];

    fx_level_detect #(
        .DATA_W  (DATA_W),
        .PARAM_W (PARAM_W)
    ) u_level (
        .audio_in    (audio_in),
        .gate_thresh (gate_thresh),
        .above_open  (above_open),
        .above_close (above_close)
    );

    assign g_sum = {1'b0, g_q} + 9'(ATTACK_STEP);
    assign g_up  = (g_sum >= 9'(GATE_UNITY)) ? GATE_UNITY : g_sum[7:0];
    assign g_dn  = (g_q > 8'(RELEASE_STEP)) ? g_q - 8'(RELEASE_STEP) : 8'd0;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        g_d     = g_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_CLOSED:  if (above_open) state_d = ST_ATTACK;
            ST_ATTACK: begin
                g_d = g_up;
                if (g_up == GATE_UNITY) state_d = ST_OPEN;
            end
            ST_OPEN: if (!above_close) begin
                state_d = ST_HOLD;
                cnt_d   = CNT_W'(HOLD_SAMPLES - 1);
            end
            ST_HOLD: begin
                if (above_close)      state_d = ST_OPEN;
                else if (cnt_q == '0) state_d = ST_RELEASE;
                else                  cnt_d   = cnt_q - 1'b1;
            end
            ST_RELEASE: begin
                if (above_open) begin
                    state_d = ST_ATTACK;
                end else begin
                    g_d = g_dn;
                    if (g_dn == 8'd0) state_d = ST_CLOSED;
                end
            end
            default: state_d = ST_CLOSED;
        endcase
    end

    // Output is scaled by the gain held before this strobe, so gain lags state by one sample.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            prod[ch]        = $signed(audio_in[ch]) * $signed({1'b0, g_q});
            audio_out_d[ch] = DATA_W'(sat16(32'(prod[ch] >>> 7), DATA_W));
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all of them sample the same pre-edge values.
        if (reset) begin
            state_q     <= ST_CLOSED;
            g_q         <= '0;
            cnt_q       <= '0;
            audio_out_q <= '0;
            gate_open_q <= 1'b0;
        end else if (sample_en) begin
            state_q     <= state_d;
            g_q         <= g_d;
            cnt_q       <= cnt_d;
            audio_out_q <= audio_out_d;
            gate_open_q <= (state_d == ST_OPEN) || (state_d == ST_HOLD);
        end
    end

    assign audio_out = audio_out_q;
    assign gate_open = gate_open_q;

endmodule
